// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed, XOR-checksummed program over a
// valid/ready byte stream, clears and then fills program memory, and releases
// the CPU once the checksum matches.
//
// Parameters
//   MEM_DEPTH       number of 8-bit program memory words
//   TIMEOUT_CYCLES  max consecutive idle (in_valid low) cycles while receiving
//
// Ports
//   clk_signal    system clock, rising edge
//   reset_n       synchronous active-low reset
//   in_valid      upstream byte valid
//   in_data       upstream byte
//   in_ready      loader accepts a byte this cycle
//   reload        single-cycle restart request (honoured in RUN / ERR only)
//   halt_signal   CPU halt indication
//   mem_we        program memory write strobe
//   mem_addr      program memory write address
//   mem_wdata     program memory write data
//   cpu_run       CPU released from reset and executing
//   load_done     load completed with a good checksum
//   load_error    load failed (bad length, bad checksum or timeout)
//   cpu_halted    CPU reported halt while running (sticky until CLEAR)
//   words_loaded  data bytes written in the current load
module program_loader #(
    parameter int unsigned MEM_DEPTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned AddrW         = $clog2(MEM_DEPTH),
    localparam int unsigned CntW          = $clog2(MEM_DEPTH + 1)
) (
    input  logic             clk_signal,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             reload,
    input  logic             halt_signal,
    output logic             mem_we,
    output logic [AddrW-1:0] mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             cpu_run,
    output logic             load_done,
    output logic             load_error,
    output logic             cpu_halted,
    output logic [CntW-1:0]  words_loaded
);

    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StClear,
        StLen,
        StData,
        StChk,
        StRun,
        StErr
    } state_e;

    state_e           state_q, state_d;
    logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
    logic [CntW-1:0]  len_q, len_d;
    logic [CntW-1:0]  words_q, words_d;
    logic [7:0]       chk_q, chk_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic             halted_q, halted_d;
    logic             we_q, we_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;

    logic receiving;
    logic xfer;
    logic timeout;
    logic len_bad;

    assign receiving = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
    assign in_ready  = receiving;
    assign xfer      = in_valid && receiving;
    // The idle cycle that would make the count reach TIMEOUT_CYCLES aborts the load.
    assign timeout   = receiving && !in_valid && (idle_q == IdleW'(TIMEOUT_CYCLES - 1));
    assign len_bad   = (in_data == 8'd0) || (32'(in_data) > MEM_DEPTH);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        len_d     = len_q;
        words_d   = words_q;
        chk_d     = chk_q;
        halted_d  = halted_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        if (!receiving || xfer) begin
            idle_d = '0;
        end else begin
            idle_d = idle_q + 1'b1;
        end

        unique case (state_q)
            StClear: begin
                // Memory writes are registered, so each cleared word appears one cycle later.
                we_d     = 1'b1;
                addr_d   = clr_cnt_q;
                wdata_d  = 8'h00;
                chk_d    = 8'h00;
                words_d  = '0;
                halted_d = 1'b0;
                if (clr_cnt_q == AddrW'(MEM_DEPTH - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = StLen;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            StLen: begin
                if (xfer) begin
                    len_d   = in_data[CntW-1:0];
                    state_d = len_bad ? StErr : StData;
                end
            end
            StData: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = words_q[AddrW-1:0];
                    wdata_d = in_data;
                    chk_d   = chk_q ^ in_data;
                    words_d = words_q + 1'b1;
                    if ((words_q + 1'b1) == len_q) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (xfer) begin
                    state_d = (in_data == chk_q) ? StRun : StErr;
                end
            end
            StRun: begin
                if (halt_signal) begin
                    halted_d = 1'b1;
                end
                if (reload) begin
                    state_d  = StClear;
                    words_d  = '0;
                    halted_d = 1'b0;
                end
            end
            StErr: begin
                if (reload) begin
                    state_d  = StClear;
                    words_d  = '0;
                    halted_d = 1'b0;
                end
            end
            default: begin
                state_d = StClear;
            end
        endcase

        if (timeout) begin
            state_d = StErr;
        end
    end

    always_ff @(posedge clk_signal) begin
        if (!reset_n) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
            len_q     <= '0;
            words_q   <= '0;
            chk_q     <= 8'h00;
            idle_q    <= '0;
            halted_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            len_q     <= len_d;
            words_q   <= words_d;
            chk_q     <= chk_d;
            idle_q    <= idle_d;
            halted_q  <= halted_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_run      = (state_q == StRun);
    assign load_done    = (state_q == StRun);
    assign load_error   = (state_q == StErr);
    assign cpu_halted   = halted_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, so they reflect the state after that edge.
module tb_program_loader;

    logic       clk_signal;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       reload;
    logic       halt_signal;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic       load_done;
    logic       load_error;
    logic       cpu_halted;
    logic [5:0] words_loaded;

    int n_checks;
    int n_fail;

    program_loader dut (
        .clk_signal   (clk_signal),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .reload       (reload),
        .halt_signal  (halt_signal),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_run      (cpu_run),
        .load_done    (load_done),
        .load_error   (load_error),
        .cpu_halted   (cpu_halted),
        .words_loaded (words_loaded)
    );

    initial begin
        clk_signal = 1'b0;
        forever #5 clk_signal = ~clk_signal;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_signal);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Entered with the DUT in CLEAR at address 0; leaves it in LEN.
    task automatic do_clear();
        for (int i = 0; i < 32; i++) begin
            tick();
            check_eq("clr_we", 32'(mem_we), 32'd1);
            check_eq("clr_addr", 32'(mem_addr), 32'(i));
            check_eq("clr_wdata", 32'(mem_wdata), 32'h00);
            check_eq("clr_ready", 32'(in_ready), (i == 31) ? 32'd1 : 32'd0);
            check_eq("clr_run", 32'(cpu_run), 32'd0);
        end
        tick();
        check_eq("len_we", 32'(mem_we), 32'd0);
        check_eq("len_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check_eq("rl_err", 32'(load_error), 32'd0);
        check_eq("rl_run", 32'(cpu_run), 32'd0);
        check_eq("rl_done", 32'(load_done), 32'd0);
        check_eq("rl_halt", 32'(cpu_halted), 32'd0);
        check_eq("rl_words", 32'(words_loaded), 32'd0);
        check_eq("rl_ready", 32'(in_ready), 32'd0);
        do_clear();
    endtask

    task automatic check_reset_vals();
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_we", 32'(mem_we), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_run", 32'(cpu_run), 32'd0);
        check_eq("rst_done", 32'(load_done), 32'd0);
        check_eq("rst_err", 32'(load_error), 32'd0);
        check_eq("rst_halt", 32'(cpu_halted), 32'd0);
        check_eq("rst_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic check_write(input string tag, input int addr, input logic [7:0] data,
                               input int words);
        check_eq({tag, "_we"}, 32'(mem_we), 32'd1);
        check_eq({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        check_eq({tag, "_wdata"}, 32'(mem_wdata), 32'(data));
        check_eq({tag, "_words"}, 32'(words_loaded), 32'(words));
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        reload      = 1'b0;
        halt_signal = 1'b0;

        // Reset values, then the clear sweep.
        tick();
        tick();
        tick();
        check_reset_vals();
        reset_n = 1'b1;
        do_clear();

        // Good load: 03 21 3F 00, checksum 1E.
        send_byte(8'h03);
        check_eq("len_we0", 32'(mem_we), 32'd0);
        send_byte(8'h21);
        check_write("d0", 0, 8'h21, 1);
        send_byte(8'h3F);
        check_write("d1", 1, 8'h3F, 2);
        send_byte(8'h00);
        check_write("d2", 2, 8'h00, 3);
        check_eq("chk_ready", 32'(in_ready), 32'd1);
        check_eq("chk_run", 32'(cpu_run), 32'd0);
        send_byte(8'h1E);
        check_eq("run_run", 32'(cpu_run), 32'd1);
        check_eq("run_done", 32'(load_done), 32'd1);
        check_eq("run_we", 32'(mem_we), 32'd0);
        check_eq("run_ready", 32'(in_ready), 32'd0);
        check_eq("run_words", 32'(words_loaded), 32'd3);
        check_eq("run_halt0", 32'(cpu_halted), 32'd0);
        halt_signal = 1'b1;
        tick();
        halt_signal = 1'b0;
        check_eq("halt_set", 32'(cpu_halted), 32'd1);
        check_eq("halt_run", 32'(cpu_run), 32'd1);
        tick();
        check_eq("halt_sticky", 32'(cpu_halted), 32'd1);
        do_reload();

        // Bad checksum 1F.
        send_byte(8'h03);
        send_byte(8'h21);
        send_byte(8'h3F);
        send_byte(8'h00);
        send_byte(8'h1F);
        check_eq("bad_err", 32'(load_error), 32'd1);
        check_eq("bad_run", 32'(cpu_run), 32'd0);
        check_eq("bad_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check_eq("bad_sticky", 32'(load_error), 32'd1);
        do_reload();

        // Length 00 and 21 are rejected without writes.
        send_byte(8'h00);
        check_eq("len0_err", 32'(load_error), 32'd1);
        check_eq("len0_we", 32'(mem_we), 32'd0);
        do_reload();
        send_byte(8'h21);
        check_eq("len33_err", 32'(load_error), 32'd1);
        check_eq("len33_we", 32'(mem_we), 32'd0);
        check_eq("len33_words", 32'(words_loaded), 32'd0);
        do_reload();

        // Reload ignored in LEN; single-word load.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check_eq("rl_ign_ready", 32'(in_ready), 32'd1);
        check_eq("rl_ign_we", 32'(mem_we), 32'd0);
        send_byte(8'h01);
        send_byte(8'hAA);
        check_write("n1", 0, 8'hAA, 1);
        send_byte(8'hAA);
        check_eq("n1_run", 32'(cpu_run), 32'd1);
        do_reload();

        // Idle timeout boundary: 254 idle cycles survive, 255 abort.
        send_byte(8'h02);
        for (int i = 0; i < 254; i++) tick();
        check_eq("idle254_err", 32'(load_error), 32'd0);
        check_eq("idle254_ready", 32'(in_ready), 32'd1);
        send_byte(8'h55);
        check_write("idle_d0", 0, 8'h55, 1);
        for (int i = 0; i < 254; i++) tick();
        check_eq("idle254b_err", 32'(load_error), 32'd0);
        tick();
        check_eq("idle255_err", 32'(load_error), 32'd1);
        check_eq("idle255_ready", 32'(in_ready), 32'd0);
        do_reload();

        // Reset in the middle of DATA.
        send_byte(8'h03);
        send_byte(8'h11);
        check_write("mid_d0", 0, 8'h11, 1);
        reset_n = 1'b0;
        tick();
        check_reset_vals();
        reset_n = 1'b1;
        do_clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 32, meaning the number of 8-bit program memory words (address width 5).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum consecutive idle cycles (in_valid low) tolerated while receiving.
REQ-003 The block SHALL have port clk_signal  input  1  system clock, all logic on rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, synchronous, active-low; clock clk_signal.
REQ-005 The block SHALL have port in_valid  input  1  upstream byte valid.
REQ-006 The block SHALL have port in_data  input  8  upstream byte.
REQ-007 The block SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 The block SHALL have port reload  input  1  single-cycle request to restart loading.
REQ-009 The block SHALL have port halt_signal  input  1  CPU halt indication (opcode 000 fetched).
REQ-010 The block SHALL have port mem_we  output  1  program memory write strobe.
REQ-011 The block SHALL have port mem_addr  output  5  program memory write address.
REQ-012 The block SHALL have port mem_wdata  output  8  program memory write data.
REQ-013 The block SHALL have port cpu_run  output  1  high = CPU released from reset and executing.
REQ-014 The block SHALL have port load_done, load_error, cpu_halted  output  1 each  status flags.
REQ-015 The block SHALL have port words_loaded  output  6  count of data bytes written in the current load.

Function
REQ-016 States SHALL be CLEAR, LEN, DATA, CHK, RUN and ERR.
REQ-017 CLEAR SHALL write 8'h00 to addresses 0..MEM_DEPTH-1, one per cycle (mem_we=1), then go to LEN after address MEM_DEPTH-1 (exactly 32 cycles).
REQ-018 in_ready SHALL be 1 only in LEN, DATA and CHK; a byte transfers on a cycle with in_valid=1 and in_ready=1.
REQ-019 In LEN, the accepted byte N SHALL be latched; N in 1..MEM_DEPTH goes to DATA, N=0 or N>MEM_DEPTH goes to ERR.
REQ-020 In DATA, the k-th accepted byte (k=0..N-1) SHALL produce mem_we=1, mem_addr=k, mem_wdata=byte on the next cycle (1-cycle registered latency).
REQ-021 words_loaded SHALL increment by 1 per DATA transfer, saturating at N; leave DATA for CHK after the N-th transfer.
REQ-022 A running checksum SHALL be the 8-bit XOR of all DATA bytes, cleared on entry to LEN.
REQ-023 In CHK, the accepted byte SHALL equal the checksum to go to RUN; mismatch goes to ERR.
REQ-024 An idle counter SHALL count consecutive LEN/DATA/CHK cycles with in_valid=0, clear on any transfer; reaching TIMEOUT_CYCLES goes to ERR.
REQ-025 RUN SHALL assert cpu_run=1 and load_done=1; mem_we=0 in all states other than CLEAR and the cycle after a DATA transfer.
REQ-026 In RUN, halt_signal=1 SHALL set cpu_halted=1 (sticky until CLEAR); cpu_run remains 1.
REQ-027 ERR SHALL assert load_error=1, cpu_run=0, in_ready=0; sticky until reload or reset.
REQ-028 reload=1 in RUN or ERR SHALL go to CLEAR next cycle, dropping cpu_run, load_done, load_error, cpu_halted and words_loaded; reload in CLEAR/LEN/DATA/CHK SHALL be ignored.
REQ-029 cpu_run SHALL never be 1 in any cycle where mem_we=1.

Reset
REQ-030 reset_n=0 at a rising edge SHALL force state CLEAR with address counter 0, from any state including mid-load.
REQ-031 Reset values SHALL be: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, load_done=0, load_error=0, cpu_halted=0, words_loaded=0; checksum and idle counter 0.

Verification
REQ-032 Reset release -> 32 cycles of mem_we=1, addr 0..31, wdata 00; then in_ready=1.
REQ-033 Stream 03, 21, 3F, 00, checksum 1E -> writes 0:21, 1:3F, 2:00; words_loaded=3; cpu_run=1, load_done=1.
REQ-034 Same stream with checksum 1F -> load_error=1, cpu_run=0, in_ready=0; reload -> CLEAR restarts.
REQ-035 Length byte 00 or 21 -> ERR on next cycle, no DATA writes.
REQ-036 After LEN accepted, in_valid held 0 for 255 cycles -> load_error=1; 254 cycles then a byte -> no error.
REQ-037 RUN with halt_signal pulsed -> cpu_halted=1; reset_n=0 mid-DATA -> all outputs to reset values, CLEAR re-runs.
